// File: rtl/uart_tx_stream_arbiter.sv
// Message-granular two-way arbiter in front of the UART TX serializer.
// Round-robin on ties; an owner that goes quiet too long loses the grant.
module uart_tx_stream_arbiter #(
  parameter int DATA_W       = 8,
  parameter int IDLE_TIMEOUT = 1000000,
  parameter int CNT_W        = 16
) (
  input  logic              sys_clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_last,
  output logic              req1_ready,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready,
  output logic [1:0]        grant,
  output logic              timeout_evt,
  output logic [CNT_W-1:0]  msg_cnt0,
  output logic [CNT_W-1:0]  msg_cnt1
);

  localparam int IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          rr;
  logic          rr_nxt;
  logic [IW-1:0] idle_cnt;
  logic          own_valid;
  logic          own_last;
  logic          hs;
  logic          stall;
  logic          expire;

  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    tx_data   = '0;
    unique case (1'b1)
      (state == OWN0): begin
        own_valid = req0_valid;
        own_last  = req0_last;
        tx_data   = req0_data;
      end
      (state == OWN1): begin
        own_valid = req1_valid;
        own_last  = req1_last;
        tx_data   = req1_data;
      end
      default: ;
    endcase
  end

  // Outputs are gated by reset so nothing leaves during a reset cycle.
  assign tx_valid   = reset & own_valid;
  assign req0_ready = reset & (state == OWN0) & tx_ready;
  assign req1_ready = reset & (state == OWN1) & tx_ready;
  assign grant      = {state == OWN1, state == OWN0};

  assign hs     = own_valid & tx_ready;
  assign stall  = (state != IDLE) & ~own_valid;
  assign expire = stall & (idle_cnt == IDLE_LAST);

  // rr == 1 means requester 0 wins the next tie.
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr;
    if (state == IDLE) begin
      if (req0_valid && req1_valid) begin
        state_nxt = rr ? OWN0 : OWN1;
      end else if (req0_valid) begin
        state_nxt = OWN0;
      end else if (req1_valid) begin
        state_nxt = OWN1;
      end
    end else if ((hs && own_last) || expire) begin
      state_nxt = IDLE;
      rr_nxt    = (state == OWN1);
    end
  end

  always_ff @(posedge sys_clock) begin
    if (!reset) begin
      state       <= IDLE;
      rr          <= 1'b1;
      idle_cnt    <= '0;
      timeout_evt <= 1'b0;
      msg_cnt0    <= '0;
      msg_cnt1    <= '0;
    end else begin
      state       <= state_nxt;
      rr          <= rr_nxt;
      timeout_evt <= expire;
      if (state == IDLE || hs || expire) begin
        idle_cnt <= '0;
      end else if (stall) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
      if (hs && own_last) begin
        if (state == OWN0) begin
          msg_cnt0 <= msg_cnt0 + 1'b1;
        end else begin
          msg_cnt1 <= msg_cnt1 + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_stream_arbiter.sv
// Bench for uart_tx_stream_arbiter: queue-driven requesters,
// per-cycle reference model with byte scoreboard, plus literal pins.
module tb_uart_tx_stream_arbiter;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0;
  logic [7:0]  req0_data = 8'h00;
  logic        req0_last = 1'b0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [7:0]  req1_data = 8'h00;
  logic        req1_last = 1'b0;
  logic        req1_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;
  logic [1:0]  grant;
  logic        timeout_evt;
  logic [15:0] msg_cnt0;
  logic [15:0] msg_cnt1;

  always #5 clk = ~clk;

  uart_tx_stream_arbiter #(
    .DATA_W(8),
    .IDLE_TIMEOUT(T),
    .CNT_W(16)
  ) dut (
    .sys_clock(clk),
    .reset(rst_n),
    .req0_valid(req0_valid),
    .req0_data(req0_data),
    .req0_last(req0_last),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_data(req1_data),
    .req1_last(req1_last),
    .req1_ready(req1_ready),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .grant(grant),
    .timeout_evt(timeout_evt),
    .msg_cnt0(msg_cnt0),
    .msg_cnt1(msg_cnt1)
  );

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] e0[$];
  logic [8:0] e1[$];
  logic [7:0] txlog[$];
  int         ownlog[$];

  int   checks = 0;
  int   errors = 0;
  bit   armed = 1'b0;
  bit   hs0 = 1'b0;
  bit   hs1 = 1'b0;
  int   n_hs1 = 0;
  int   cyc = 0;
  int   to_cnt = 0;
  int   to_cyc = 0;
  int   hs0_cyc = 0;
  bit   to_prev = 1'b0;
  logic [1:0] g_after_to = 2'b00;

  // Model: owner 0=none,1=req0,2=req1; pref = index that wins a tie.
  int m_own = 0;
  int m_pref = 0;
  int m_idle = 0;
  int m_cnt0 = 0;
  int m_cnt1 = 0;
  bit m_to = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic push(int r, logic [7:0] d, bit l);
    if (r == 0) begin
      q0.push_back({l, d});
      e0.push_back({l, d});
    end else begin
      q1.push_back({l, d});
      e1.push_back({l, d});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic log_is(string nm, input logic [7:0] ex[$]);
    chk({nm, "_len"}, 32'(txlog.size()), 32'(ex.size()));
    foreach (ex[i]) chk(nm, 32'(txlog[i]), 32'(ex[i]));
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (hs0 && q0.size() > 0) q0.delete(0);
    if (hs1 && q1.size() > 0) q1.delete(0);
    req0_valid = q0.size() > 0;
    req0_data  = q0.size() > 0 ? q0[0][7:0] : 8'h00;
    req0_last  = q0.size() > 0 ? q0[0][8] : 1'b0;
    req1_valid = q1.size() > 0;
    req1_data  = q1.size() > 0 ? q1[0][7:0] : 8'h00;
    req1_last  = q1.size() > 0 ? q1[0][8] : 1'b0;
  end

  always @(negedge clk) begin : mon
    logic       xv;
    bit         xhs;
    bit         mv;
    logic [8:0] ent;
    cyc++;
    hs0 = req0_valid & req0_ready;
    hs1 = req1_valid & req1_ready;
    if (hs1) n_hs1++;
    if (hs0) hs0_cyc = cyc;
    if (to_prev) g_after_to = grant;
    to_prev = timeout_evt;
    if (timeout_evt) begin
      to_cnt++;
      to_cyc = cyc;
    end
    if (armed) begin
      xv = rst_n && ((m_own == 1 && req0_valid) ||
                     (m_own == 2 && req1_valid));
      chk("grant", 32'(grant), {30'd0, m_own == 2, m_own == 1});
      chk("tx_valid", 32'(tx_valid), 32'(xv));
      chk("req0_ready", 32'(req0_ready),
          32'(rst_n && m_own == 1 && tx_ready));
      chk("req1_ready", 32'(req1_ready),
          32'(rst_n && m_own == 2 && tx_ready));
      chk("timeout_evt", 32'(timeout_evt), 32'(m_to));
      chk("msg_cnt0", 32'(msg_cnt0), 32'(m_cnt0[15:0]));
      chk("msg_cnt1", 32'(msg_cnt1), 32'(m_cnt1[15:0]));
      xhs = xv && tx_ready;
      mv  = (m_own == 1) ? req0_valid : req1_valid;
      m_to = 1'b0;
      if (!rst_n) begin
        m_own  = 0;
        m_pref = 0;
        m_idle = 0;
        m_cnt0 = 0;
        m_cnt1 = 0;
      end else if (m_own == 0) begin
        if (req0_valid && req1_valid) m_own = m_pref + 1;
        else if (req0_valid) m_own = 1;
        else if (req1_valid) m_own = 2;
        m_idle = 0;
        if (m_own != 0) ownlog.push_back(m_own);
      end else if (xhs) begin
        chk("sb_has_byte",
            32'((m_own == 1) ? e0.size() : e1.size()) , 32'(
            ((m_own == 1) ? e0.size() : e1.size()) > 0 ?
            ((m_own == 1) ? e0.size() : e1.size()) : 1));
        ent = 9'h100;
        if (m_own == 1 && e0.size() > 0) ent = e0.pop_front();
        if (m_own == 2 && e1.size() > 0) ent = e1.pop_front();
        chk("tx_data", 32'(tx_data), 32'(ent[7:0]));
        txlog.push_back(tx_data);
        m_idle = 0;
        if (ent[8]) begin
          if (m_own == 1) m_cnt0++;
          else m_cnt1++;
          m_pref = 2 - m_own;
          m_own  = 0;
        end
      end else if (!mv) begin
        m_idle++;
        if (m_idle == T) begin
          m_to   = 1'b1;
          m_pref = 2 - m_own;
          m_own  = 0;
          m_idle = 0;
        end
      end
    end
  end

  initial begin
    logic [7:0] x[$];
    int base;
    // Reset with both requesters holding a message.
    push(0, 8'h41, 1'b0);
    push(0, 8'h42, 1'b1);
    push(1, 8'h61, 1'b0);
    push(1, 8'h62, 1'b1);
    step();
    armed = 1'b1;
    step();
    chk("t1_rst_grant", 32'(grant), 32'd0);
    chk("t1_rst_txv", 32'(tx_valid), 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_gap_grant", 32'(grant), 32'd0);
    chk("t1_gap_txv", 32'(tx_valid), 32'd0);
    @(negedge clk);
    chk("t1_first_grant", 32'(grant), 32'd1);
    repeat (12) step();
    x = {8'h41, 8'h42, 8'h61, 8'h62};
    log_is("t1_log", x);
    chk("t1_cnt0", 32'(msg_cnt0), 32'd1);
    chk("t1_cnt1", 32'(msg_cnt1), 32'd1);

    // Continuous ties alternate owners message by message.
    txlog.delete();
    ownlog.delete();
    for (int m = 0; m < 2; m++) begin
      for (int b = 0; b < 3; b++) begin
        push(0, 8'hA1 + 8'(3 * m + b), b == 2);
        push(1, 8'hB1 + 8'(3 * m + b), b == 2);
      end
    end
    repeat (25) step();
    x = {8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2, 8'hB3,
         8'hA4, 8'hA5, 8'hA6, 8'hB4, 8'hB5, 8'hB6};
    log_is("t2_log", x);
    chk("t2_own_len", 32'(ownlog.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("t2_owner", 32'(ownlog[i]), 32'((i % 2) + 1));
    chk("t2_cnt0", 32'(msg_cnt0), 32'd3);
    chk("t2_cnt1", 32'(msg_cnt1), 32'd3);

    // Long backpressured message must never time out.
    txlog.delete();
    for (int i = 0; i < 20; i++) push(1, 8'h80 + 8'(i), i == 19);
    for (int i = 0; i < 48; i++) begin
      tx_ready = (i % 4 == 0) || (i % 4 == 3);
      step();
    end
    tx_ready = 1'b1;
    repeat (4) step();
    chk("t3_bytes", 32'(txlog.size()), 32'd20);
    chk("t3_no_timeout", 32'(to_cnt), 32'd0);
    chk("t3_cnt1", 32'(msg_cnt1), 32'd4);

    // Stalled owner loses the grant after T idle cycles.
    txlog.delete();
    push(0, 8'h55, 1'b0);
    repeat (5) step();
    push(1, 8'hC1, 1'b0);
    push(1, 8'hC2, 1'b1);
    repeat (30) step();
    chk("t4_to_cnt", 32'(to_cnt), 32'd1);
    chk("t4_to_delay", 32'(to_cyc - hs0_cyc), 32'd17);
    chk("t4_next_grant", 32'(g_after_to), 32'd2);
    chk("t4_cnt0", 32'(msg_cnt0), 32'd3);
    chk("t4_cnt1", 32'(msg_cnt1), 32'd5);
    x = {8'h55, 8'hC1, 8'hC2};
    log_is("t4_log", x);

    // Reset in the middle of a req1 message.
    push(0, 8'hF1, 1'b1);
    for (int i = 0; i < 5; i++) push(1, 8'hD1 + 8'(i), i == 4);
    base = n_hs1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (n_hs1 - base >= 2) break;
    end
    chk("t5_hs_before_rst", 32'(n_hs1 - base), 32'd2);
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    e0.delete();
    e1.delete();
    @(negedge clk);
    chk("t5_rst_txv", 32'(tx_valid), 32'd0);
    step();
    push(0, 8'hE1, 1'b1);
    push(1, 8'h71, 1'b1);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_cnt1_cleared", 32'(msg_cnt1), 32'd0);
    chk("t5_gap_grant", 32'(grant), 32'd0);
    @(negedge clk);
    chk("t5_grant_rr", 32'(grant), 32'd1);
    repeat (8) step();
    chk("t5_cnt0", 32'(msg_cnt0), 32'd1);
    chk("t5_cnt1", 32'(msg_cnt1), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
